escalonador_round_robin: RTL

//  Multi-process preemption/scheduling manager between the OS (SO) and NUM_PROC user programs.

---
 rtl/escalonador_round_robin.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/escalonador_round_robin.sv
// Round-robin preemption manager between the OS (PID 0) and NUM_PROC user processes.
// Optional per-PID dispatch statistics are enabled by defining ESCALONADOR_STATS_EN.
module escalonador_round_robin #(
    parameter int unsigned NUM_PROC  = 4,
    parameter int unsigned PID_W     = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned QUANT_W   = 5,
    parameter int unsigned QUANT_RST = 30
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              jump_req,
    input  logic [PID_W-1:0]  jump_pid,
    input  logic              tick,
    input  logic              halt,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [PID_W-1:0]  cfg_pid,
    input  logic [ADDR_W-1:0] cfg_data,
    output logic              tem_desloc_PC,
    output logic              tem_desloc_MD,
    output logic [ADDR_W-1:0] base_to_desloc_PC,
    output logic [ADDR_W-1:0] base_to_desloc_MD,
    output logic              reset_geral,
    output logic              flag_preempcao,
    output logic              causa_halt,
    output logic [PID_W-1:0]  pid_ativo,
    output logic [PID_W-1:0]  pid_proximo,
    output logic              erro_despacho
`ifdef ESCALONADOR_STATS_EN
    ,
    input  logic [PID_W-1:0]  stat_pid,
    output logic [15:0]       stat_trocas
`endif
);

    typedef enum logic [1:0] {StSo, StDisp, StRun, StPreempt} state_e;

    state_e              state_q, state_d;
    logic                tem_q, tem_d;
    logic [ADDR_W-1:0]   base_pc_q, base_pc_d;
    logic [ADDR_W-1:0]   base_md_q, base_md_d;
    logic                reset_geral_q, reset_geral_d;
    logic                flag_q, flag_d;
    logic                causa_q, causa_d;
    logic                erro_q, erro_d;
    logic [PID_W-1:0]    pid_ativo_q, pid_ativo_d;
    logic [PID_W-1:0]    last_pid_q, last_pid_d;
    logic [PID_W-1:0]    pid_prox_q, pid_prox_d;
    logic [QUANT_W-1:0]  cnt_q, cnt_d;
    logic [QUANT_W-1:0]  quantum_q, quantum_d;
    logic [NUM_PROC:1]   alive_q, alive_d;
    logic [ADDR_W-1:0]   mi_base_q [1:NUM_PROC];
    logic [ADDR_W-1:0]   mi_base_d [1:NUM_PROC];
    logic [ADDR_W-1:0]   md_base_q [1:NUM_PROC];
    logic [ADDR_W-1:0]   md_base_d [1:NUM_PROC];

    logic jump_valid, jump_ok, cfg_valid;

    assign jump_valid = (jump_pid != '0) && (jump_pid <= PID_W'(NUM_PROC));
    assign jump_ok    = jump_valid && alive_q[jump_pid];
    assign cfg_valid  = (cfg_pid != '0) && (cfg_pid <= PID_W'(NUM_PROC));

    always_comb begin
        state_d       = state_q;
        tem_d         = tem_q;
        base_pc_d     = base_pc_q;
        base_md_d     = base_md_q;
        reset_geral_d = 1'b0;
        flag_d        = 1'b0;
        causa_d       = 1'b0;
        erro_d        = 1'b0;
        pid_ativo_d   = pid_ativo_q;
        last_pid_d    = last_pid_q;
        cnt_d         = cnt_q;
        quantum_d     = quantum_q;
        alive_d       = alive_q;
        mi_base_d     = mi_base_q;
        md_base_d     = md_base_q;

        if (jump_req && !((state_q == StSo) && jump_ok)) begin
            erro_d = 1'b1;
        end

        case (state_q)
            StSo: begin
                if (jump_req && jump_ok) begin
                    state_d       = StDisp;
                    tem_d         = 1'b1;
                    base_pc_d     = mi_base_q[jump_pid];
                    base_md_d     = md_base_q[jump_pid];
                    reset_geral_d = 1'b1;
                    pid_ativo_d   = jump_pid;
                    cnt_d         = quantum_q;
                end
            end
            StDisp: state_d = StRun;
            StRun: begin
                // Halt has priority over quantum expiry in the same cycle.
                if (halt) begin
                    state_d                = StPreempt;
                    causa_d                = 1'b1;
                    alive_d[pid_ativo_q]   = 1'b0;
                end else if (tick && (cnt_q == QUANT_W'(1))) begin
                    state_d = StPreempt;
                end else if (tick && (cnt_q != '0)) begin
                    // A zero quantum never counts down, so the process runs until halt.
                    cnt_d = cnt_q - QUANT_W'(1);
                end
                if (state_d == StPreempt) begin
                    flag_d        = 1'b1;
                    reset_geral_d = 1'b1;
                    tem_d         = 1'b0;
                    last_pid_d    = pid_ativo_q;
                    pid_ativo_d   = '0;
                end
            end
            StPreempt: state_d = StSo;
            default:   state_d = StSo;
        endcase

        if (cfg_we) begin
            unique case (cfg_sel)
                2'd0: begin
                    if (cfg_valid) begin
                        mi_base_d[cfg_pid] = cfg_data;
                        alive_d[cfg_pid]   = 1'b1;
                    end
                end
                2'd1: begin
                    if (cfg_valid) begin
                        md_base_d[cfg_pid] = cfg_data;
                    end
                end
                2'd2:    quantum_d = cfg_data[QUANT_W-1:0];
                default: ;
            endcase
        end
    end

    // Next-runnable suggestion is computed from next-state values so it is registered in step.
    always_comb begin
        logic             found;
        logic [PID_W-1:0] cand;
        found      = 1'b0;
        cand       = '0;
        pid_prox_d = '0;
        for (int i = 1; i <= int'(NUM_PROC); i++) begin
            cand = PID_W'(((int'(last_pid_d) + i - 1) % int'(NUM_PROC)) + 1);
            if (!found && alive_d[cand]) begin
                pid_prox_d = cand;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StSo;
            tem_q         <= 1'b0;
            base_pc_q     <= '0;
            base_md_q     <= '0;
            reset_geral_q <= 1'b0;
            flag_q        <= 1'b0;
            causa_q       <= 1'b0;
            erro_q        <= 1'b0;
            pid_ativo_q   <= '0;
            last_pid_q    <= '0;
            pid_prox_q    <= '0;
            cnt_q         <= '0;
            quantum_q     <= QUANT_W'(QUANT_RST);
            alive_q       <= '1;
            for (int i = 1; i <= int'(NUM_PROC); i++) begin
                mi_base_q[i] <= '0;
                md_base_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            tem_q         <= tem_d;
            base_pc_q     <= base_pc_d;
            base_md_q     <= base_md_d;
            reset_geral_q <= reset_geral_d;
            flag_q        <= flag_d;
            causa_q       <= causa_d;
            erro_q        <= erro_d;
            pid_ativo_q   <= pid_ativo_d;
            last_pid_q    <= last_pid_d;
            pid_prox_q    <= pid_prox_d;
            cnt_q         <= cnt_d;
            quantum_q     <= quantum_d;
            alive_q       <= alive_d;
            mi_base_q     <= mi_base_d;
            md_base_q     <= md_base_d;
        end
    end

    assign tem_desloc_PC     = tem_q;
    assign tem_desloc_MD     = tem_q;
    assign base_to_desloc_PC = base_pc_q;
    assign base_to_desloc_MD = base_md_q;
    assign reset_geral       = reset_geral_q;
    assign flag_preempcao    = flag_q;
    assign causa_halt        = causa_q;
    assign pid_ativo         = pid_ativo_q;
    assign pid_proximo       = pid_prox_q;
    assign erro_despacho     = erro_q;

`ifdef ESCALONADOR_STATS_EN
    logic [15:0] stat_q [1:NUM_PROC];
    logic        stat_valid;

    assign stat_valid = (stat_pid != '0) && (stat_pid <= PID_W'(NUM_PROC));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i <= int'(NUM_PROC); i++) begin
                stat_q[i] <= '0;
            end
        end else if ((state_q == StDisp) && (stat_q[pid_ativo_q] != 16'hFFFF)) begin
            stat_q[pid_ativo_q] <= stat_q[pid_ativo_q] + 16'd1;
        end
    end

    assign stat_trocas = stat_valid ? stat_q[stat_pid] : 16'd0;
`endif

endmodule
